clk_tick_gen: RTL and testbench

//   Multi-channel, runtime-programmable timebase for the game fabric. Each channel

---
 rtl/clk_tick_gen.sv | 77 +++++++
 tb/tb_clk_tick_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel runtime-programmable tick/square timebase.
// Ports: clk, rst, en, sync, wr_en/wr_ch/wr_div in; tick, sq out.
module clk_tick_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
    {32'd50_000, 32'd50_000_000},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W:0]   ONE_W = 1;
  localparam logic [CNT_W-1:0] ONE_C = 1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W:0]   div_m1;
    logic [CNT_W:0]   div_h;
    logic             tick_q;
    logic             sq_q;
    logic             wrap;
    logic             hit;
    logic             sq_nx;

    // Widened by one bit so div==0 never matches.
    assign div_m1 = {1'b0, div_q} - ONE_W;
    assign div_h  = ({1'b0, div_q} + ONE_W) >> 1;
    assign wrap   = ({1'b0, cnt_q} == div_m1);
    assign cnt_nx = wrap ? '0 : cnt_q + ONE_C;
    assign sq_nx  = ({1'b0, cnt_nx} < div_h);
    // Out-of-range wr_ch never equals a valid index.
    assign hit    = wr_en && (wr_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        div_q  <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else if (hit) begin
        div_q  <= wr_div;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= (wr_div != '0);
      end else if (sync) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= (div_q != '0);
      end else if (div_q == '0) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else if (!en[i]) begin
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_nx;
        tick_q <= wrap;
        sq_q   <= sq_nx;
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: scoreboard bench for clk_tick_gen.
// Driver pushes model results; monitor pops and compares.
module tb_clk_tick_gen;

  localparam int NC = 3;
  localparam int CW = 8;

  typedef struct packed {
    logic [NC-1:0] t;
    logic [NC-1:0] s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NC-1:0] en = '0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [CW-1:0] wr_div = '0;
  logic [NC-1:0] tick;
  logic [NC-1:0] sq;

  clk_tick_gen #(
    .NUM_CH  (NC),
    .CNT_W   (CW),
    .DIV_INIT(24'h07_05_04)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .sync  (sync),
    .wr_en (wr_en),
    .wr_ch (wr_ch),
    .wr_div(wr_div),
    .tick  (tick),
    .sq    (sq)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference: ph = cycles elapsed in the current period.
  int   mdiv[NC];
  int   mph[NC];
  bit   mt[NC];
  bit   ms[NC];
  int   init_div[NC] = '{4, 5, 7};

  task automatic model(input bit r, input logic [NC-1:0] e,
                       input bit s, input bit w,
                       input int wc, input int wd);
    exp_t x;
    for (int i = 0; i < NC; i++) begin
      if (r) begin
        mdiv[i] = init_div[i]; mph[i] = 0;
        mt[i] = 0; ms[i] = 0;
      end else if (w && wc == i) begin
        mdiv[i] = wd; mph[i] = 0;
        mt[i] = 0; ms[i] = (wd != 0);
      end else if (s) begin
        mph[i] = 0; mt[i] = 0; ms[i] = (mdiv[i] != 0);
      end else if (mdiv[i] == 0) begin
        mph[i] = 0; mt[i] = 0; ms[i] = 0;
      end else if (!e[i]) begin
        mt[i] = 0;
      end else begin
        mph[i] = (mph[i] + 1) % mdiv[i];
        mt[i] = (mph[i] == 0);
        ms[i] = (mph[i] < (mdiv[i] + 1) / 2);
      end
      x.t[i] = mt[i];
      x.s[i] = ms[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic step(input bit r, input logic [NC-1:0] e,
                      input bit s, input bit w,
                      input int wc, input int wd);
    @(negedge clk);
    rst = r; en = e; sync = s; wr_en = w;
    wr_ch = 2'(wc); wr_div = CW'(wd);
    model(r, e, s, w, wc, wd);
  endtask

  task automatic run(input int n, input logic [NC-1:0] e);
    for (int k = 0; k < n; k++) step(0, e, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_tests++;
        if (tick !== x.t || sq !== x.s) begin
          n_fail++;
          $display("FAIL out cyc%0d tick=%b exp %b sq=%b exp %b",
                   cyc, tick, x.t, sq, x.s);
        end
      end
    end
  end

  initial begin : driver
    int k;
    logic [NC-1:0] e;
    for (int i = 0; i < 3; i++) step(1, '0, 0, 0, 0, 0);
    run(20, 3'b111);
    run(2, 3'b111);
    step(0, 3'b111, 0, 1, 0, 3);
    run(8, 3'b111);
    step(0, 3'b111, 0, 1, 0, 0);
    run(6, 3'b111);
    step(0, 3'b111, 0, 1, 0, 1);
    run(5, 3'b111);
    step(0, 3'b111, 0, 1, 0, 6);
    run(3, 3'b111);
    run(7, 3'b110);
    run(8, 3'b111);
    k = 0;
    while (k < 300 && mph[1] != mdiv[1] - 1) begin
      run(1, 3'b111);
      k++;
    end
    n_tests++;
    if (mph[1] != mdiv[1] - 1) begin
      n_fail++;
      $display("FAIL wrap_seek ph=%0d exp %0d", mph[1], mdiv[1] - 1);
    end
    step(0, 3'b111, 0, 1, 1, 5);
    run(12, 3'b111);
    step(0, 3'b111, 1, 0, 0, 0);
    run(15, 3'b111);
    step(0, 3'b111, 0, 1, 3, 9);
    run(12, 3'b111);
    run(2, 3'b111);
    step(1, 3'b111, 0, 0, 0, 0);
    run(16, 3'b111);
    step(0, 3'b111, 0, 1, 2, 255);
    run(260, 3'b111);
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(0, 299) == 0)
        step(1, e, 0, 0, 0, 0);
      else if ($urandom_range(0, 14) == 0)
        step(0, e, $urandom_range(0, 9) == 0, 1,
             $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? 255
                                         : $urandom_range(0, 9));
      else
        step(0, e, $urandom_range(0, 39) == 0, 0, 0, 0);
    end
    step(0, 3'b111, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
